// File: rtl/qr_pkg.sv
// Shared types and constants for the QR finder-pattern pipeline: image geometry,
// scanner states, pixel pipeline tag and the 1:1:3:1:1 ratio test.
package qr_pkg;

    localparam int IMG_SIZE = 480;
    localparam int ADDR_W   = 18;
    localparam int IDX_W    = 9;
    localparam int RUN_W    = 9;
    localparam int SUM_W    = 12;
    localparam int PROD_W   = 13;

    localparam logic [PROD_W-1:0] RATIO_DEN       = 13'd14;
    localparam logic [PROD_W-1:0] RATIO_OUTER_HI  = 13'd3;
    localparam logic [PROD_W-1:0] RATIO_CENTER_LO = 13'd5;
    localparam logic [PROD_W-1:0] RATIO_CENTER_HI = 13'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HORZ,
        ST_VERT,
        ST_DONE
    } scan_state_t;

    typedef logic [RUN_W-1:0] run_t;
    typedef logic [4:0][RUN_W-1:0] run_vec_t;   // [0] is the newest run

    typedef struct packed {
        logic             valid;
        logic             eol;
        logic             vert;
        logic [IDX_W-1:0] line;
    } pix_tag_t;

    // Runs are in order black,white,black,white,black; index 2 is the center.
    function automatic logic ratio_match(input run_vec_t runs);
        logic [SUM_W-1:0]  total;
        logic [PROD_W-1:0] t;
        logic [PROD_W-1:0] p;
        logic              ok;
        total = '0;
        for (int i = 0; i < 5; i++) total = total + SUM_W'(runs[i]);
        t  = PROD_W'(total);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            p = RATIO_DEN * PROD_W'(runs[i]);
            if (i == 2) ok = ok && (RATIO_CENTER_LO * t <= p) && (p <= RATIO_CENTER_HI * t);
            else        ok = ok && (t <= p) && (p <= RATIO_OUTER_HI * t);
        end
        return ok;
    endfunction

endpackage

// File: rtl/run_ratio_checker.sv
// Black/white run tracker along one scan line; pulses match for one cycle when a
// pushed black run completes a 1:1:3:1:1 sequence of the last five runs.
module run_ratio_checker
    import qr_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic pixel,
    input  logic valid,
    input  logic end_of_line,
    output logic match
);

    run_vec_t   shift_q;
    run_t       run_len_q;
    logic       color_q;
    logic [2:0] count_q;

    logic     change;
    run_t     run_inc;
    run_vec_t push_a;
    run_vec_t push_b;
    logic     eval_a;
    logic     eval_b;

    // An end-of-line pixel can cause two pushes at once: the color-change push
    // (push_a) and the final run of the line (push_b); both are evaluated.
    always_comb begin
        change  = (run_len_q != '0) && (pixel != color_q);
        run_inc = (run_len_q == '1) ? run_len_q : run_len_q + RUN_W'(1);
        push_a  = {shift_q[3:0], run_len_q};
        eval_a  = change && color_q && (count_q >= 3'd4) && ratio_match(push_a);
        if (change) push_b = {shift_q[2:0], run_len_q, RUN_W'(1)};
        else        push_b = {shift_q[3:0], run_inc};
        eval_b  = end_of_line && pixel
                  && (({1'b0, count_q} + 4'(change)) >= 4'd4) && ratio_match(push_b);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shift_q   <= '0;
            run_len_q <= '0;
            color_q   <= 1'b0;
            count_q   <= '0;
            match     <= 1'b0;
        end else begin
            match <= valid && (eval_a || eval_b);
            if (valid) begin
                if (end_of_line) begin
                    shift_q   <= '0;
                    run_len_q <= '0;
                    color_q   <= 1'b0;
                    count_q   <= '0;
                end else if (run_len_q == '0) begin
                    color_q   <= pixel;
                    run_len_q <= RUN_W'(1);
                end else if (change) begin
                    shift_q   <= push_a;
                    count_q   <= (count_q == 3'd5) ? count_q : count_q + 3'd1;
                    color_q   <= pixel;
                    run_len_q <= RUN_W'(1);
                end else begin
                    run_len_q <= run_inc;
                end
            end
        end
    end

endmodule

// File: rtl/finder_line_scanner.sv
// Two-pass (row-major, then column-major) finder-pattern line scanner over the
// binarized frame buffer. Define FINDER_BOUNDS_EN to track min/max flagged lines.
module finder_line_scanner
    import qr_pkg::*;
#(
    parameter int IMG_SIZE     = qr_pkg::IMG_SIZE,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start_scan,
    output logic [ADDR_W-1:0]       pixel_addr,
    input  logic                    pixel_data,
    output logic [IMG_SIZE-1:0]     horz_patterns,
    output logic [IMG_SIZE-1:0]     vert_patterns,
    output logic [1:0][IDX_W-1:0]   bound_x,
    output logic [1:0][IDX_W-1:0]   bound_y,
    output logic                    busy,
    output logic                    scan_done
);

    localparam int                       LINE_W      = $clog2(IMG_SIZE);
    localparam logic [IDX_W-1:0]         LAST_IDX    = IDX_W'(IMG_SIZE - 1);
    localparam logic [ADDR_W-1:0]        ROW_STEP    = ADDR_W'(IMG_SIZE);
    localparam logic [7:0]               DRAIN_LAST  = 8'(READ_LATENCY + 1);
    localparam logic [1:0][IDX_W-1:0]    BOUND_RESET = {LAST_IDX, IDX_W'(0)};

    scan_state_t      state;
    logic [IDX_W-1:0] col;
    logic [IDX_W-1:0] row;
    logic             issuing;
    logic [7:0]       drain_cnt;
    pix_tag_t         issue_tag;
    pix_tag_t         pipe [READ_LATENCY];
    logic             match;
    logic [IDX_W-1:0] match_line;
    logic             match_vert;
    logic             start_accept;

    assign start_accept = start_scan && (state == ST_IDLE);

    always_comb begin
        // NOTE: default the whole struct first so no path infers a latch.
        issue_tag       = '0;
        issue_tag.valid = issuing;
        issue_tag.vert  = (state == ST_VERT);
        issue_tag.line  = (state == ST_VERT) ? col : row;
        issue_tag.eol   = (state == ST_VERT) ? (row == LAST_IDX) : (col == LAST_IDX);
    end

    // Tags ride alongside the BRAM read so they line up with pixel_data.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: only valid bits need reset; line/eol/vert are qualified by valid.
            for (int i = 0; i < READ_LATENCY; i++) pipe[i].valid <= 1'b0;
        end else begin
            pipe[0] <= issue_tag;
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
        match_line <= pipe[READ_LATENCY-1].line;
        match_vert <= pipe[READ_LATENCY-1].vert;
    end

    run_ratio_checker u_checker (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .pixel       (pixel_data),
        .valid       (pipe[READ_LATENCY-1].valid),
        .end_of_line (pipe[READ_LATENCY-1].eol),
        .match       (match)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= ST_IDLE;
            pixel_addr    <= '0;
            col           <= '0;
            row           <= '0;
            issuing       <= 1'b0;
            drain_cnt     <= '0;
            busy          <= 1'b0;
            scan_done     <= 1'b0;
            horz_patterns <= '0;
            vert_patterns <= '0;
        end else begin
            scan_done <= 1'b0;
            if (match) begin
                if (match_vert) vert_patterns[match_line[LINE_W-1:0]] <= 1'b1;
                else            horz_patterns[match_line[LINE_W-1:0]] <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start_scan) begin
                        state         <= ST_HORZ;
                        busy          <= 1'b1;
                        pixel_addr    <= '0;
                        col           <= '0;
                        row           <= '0;
                        issuing       <= 1'b1;
                        drain_cnt     <= '0;
                        horz_patterns <= '0;
                        vert_patterns <= '0;
                    end
                end
                ST_HORZ, ST_VERT: begin
                    if (issuing) begin
                        if (col == LAST_IDX && row == LAST_IDX) begin
                            issuing <= 1'b0;
                        end else if (state == ST_HORZ) begin
                            pixel_addr <= pixel_addr + ADDR_W'(1);
                            if (col == LAST_IDX) begin
                                col <= '0;
                                row <= row + IDX_W'(1);
                            end else begin
                                col <= col + IDX_W'(1);
                            end
                        end else if (row == LAST_IDX) begin
                            // Column end: rebase to the top of the next column.
                            pixel_addr <= ADDR_W'(col) + ADDR_W'(1);
                            row        <= '0;
                            col        <= col + IDX_W'(1);
                        end else begin
                            pixel_addr <= pixel_addr + ROW_STEP;
                            row        <= row + IDX_W'(1);
                        end
                    end else if (drain_cnt == DRAIN_LAST) begin
                        drain_cnt  <= '0;
                        pixel_addr <= '0;
                        col        <= '0;
                        row        <= '0;
                        if (state == ST_HORZ) begin
                            state   <= ST_VERT;
                            issuing <= 1'b1;
                        end else begin
                            state     <= ST_DONE;
                            busy      <= 1'b0;
                            scan_done <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FINDER_BOUNDS_EN
    logic horz_any;
    logic vert_any;

    always_ff @(posedge clk_in) begin
        if (rst_in || start_accept) begin
            bound_x  <= BOUND_RESET;
            bound_y  <= BOUND_RESET;
            horz_any <= 1'b0;
            vert_any <= 1'b0;
        end else if (match) begin
            if (match_vert) begin
                vert_any <= 1'b1;
                if (!vert_any) begin
                    bound_x <= {match_line, match_line};
                end else begin
                    if (match_line < bound_x[0]) bound_x[0] <= match_line;
                    if (match_line > bound_x[1]) bound_x[1] <= match_line;
                end
            end else begin
                horz_any <= 1'b1;
                if (!horz_any) begin
                    bound_y <= {match_line, match_line};
                end else begin
                    if (match_line < bound_y[0]) bound_y[0] <= match_line;
                    if (match_line > bound_y[1]) bound_y[1] <= match_line;
                end
            end
        end
    end
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
    assign bound_x = BOUND_RESET;
    assign bound_y = BOUND_RESET;
`endif

endmodule

// File: doc/finder_line_scanner.md
# finder_line_scanner

Produces the per-row and per-column finder-pattern flag vectors consumed by the cross-pattern center locator. It scans the 480x480 binarized frame in BRAM twice, row-major then column-major, and tracks black/white run lengths along each line. It flags every line that contains a 1:1:3:1:1 (black:white:black:white:black) sequence. It sits between the frame-buffer binarizer and the center locator: its done pulse is the start strobe for that stage.

## Interface
- IMG_SIZE, 480: square image side in pixels; also the flag-vector width.
- READ_LATENCY, 2: cycles from pixel_addr to valid pixel_data.
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- start_scan  input  1  one-cycle start strobe; accepted only in IDLE.
- pixel_addr  output  18  frame-buffer read address, y*IMG_SIZE+x.
- pixel_data  input  1  pixel at the address issued READ_LATENCY cycles earlier; 1 = dark module.
- horz_patterns  output  IMG_SIZE  bit y set when row y contains the ratio.
- vert_patterns  output  IMG_SIZE  bit x set when column x contains the ratio.
- bound_x  output  2x9  [0]/[1] = lowest/highest set index of vert_patterns.
- bound_y  output  2x9  [0]/[1] = lowest/highest set index of horz_patterns.
- busy  output  1  high from accepted start through the cycle before scan_done.
- scan_done  output  1  one-cycle pulse; outputs are stable and valid from this cycle until the next accepted start.

## Operation
- States: IDLE -> HORZ -> VERT -> DONE -> IDLE. DONE lasts one cycle and asserts scan_done.
- Accepted start: clear both flag vectors, set bounds to reset values, enter HORZ.
- HORZ: issue one address per cycle, x fastest. The address is an incrementing counter with no multiplier. After the last address, wait READ_LATENCY+2 cycles for the pipeline to drain, then enter VERT.
- VERT: y fastest. The address steps by IMG_SIZE and rebases to x+1 at the column end. Drain is the same as HORZ.
- The pixel pipeline carries a line-index tag and an end-of-line tag alongside each returned pixel.
- Run tracker keeps a 5-deep shift of completed run lengths (9 bits each, saturating at 511), plus the current run and the color of the current run.
  - A color change pushes the current run into the shift.
  - The line end also pushes the current run, then clears all state.
  - Runs never span lines.
- Evaluate on every push whose newest run is black and whose shift holds 5 valid runs. With T = sum of the 5 runs (12 bits), the match requires:
  - each outer and white run r: T <= 14r <= 3T;
  - the center run c: 5T <= 14c <= 7T.
  - Comparisons use 13-bit products; no division.
- Match: set bit[line] in the active vector. Multiple matches on one line are idempotent.
- A pattern touching the image edge counts; the line start behaves as a color change.
- Bounds update on each new set bit (min/max), with registers tracking both vectors.
- start_scan while busy or in DONE: ignored.

## Timing
- Reset values: every flag bit 0; bound_x/bound_y = {0, IMG_SIZE-1}; pixel_addr 0; busy 0; scan_done 0; state IDLE.
- Reset mid-scan returns to IDLE on the next edge and discards partial results. No done pulse follows.
- start accepted at edge E: busy high from E+1.
- Each pass takes IMG_SIZE^2 + READ_LATENCY + 2 cycles.
- scan_done is high exactly 2*(IMG_SIZE^2 + READ_LATENCY + 2) + 1 cycles after E; busy drops in that same cycle.
- A flag bit becomes visible 1 cycle after its line's evaluating push.

## Configuration
- FINDER_BOUNDS_EN defined: bound_x/bound_y are computed as above. If a vector has no set bit at done, its bound pair keeps the reset values.
- FINDER_BOUNDS_EN undefined: bound tracking logic is removed, and the bounds are held at {0, IMG_SIZE-1}.

## Structure
- Shared package qr_pkg holds:
  - IMG_SIZE and the address width;
  - the scanner state enum;
  - ratio constants 14, 3, 5, 7.
- One sub-module, run_ratio_checker, is instantiated once and shared by both passes. It contains the run tracker and the ratio compare. Its inputs are pixel, valid and end_of_line; its output is a one-cycle match.

## Test plan
- All-white frame, start -> no flag bits set; bounds {0,479}; scan_done at E+2*(230400+4)+1.
- Single 63x63 finder with 9-px modules at x,y 50..112 -> horz_patterns[68..94]=1 and vert_patterns[68..94]=1, all other bits 0; bound_x={68,94}, bound_y={68,94}.
- Rows 50..58 are solid black and rows 59..67 give 1:5:1 -> those rows stay 0. The same finder with the center run 45 px (9,9,45,9,9) -> no match.
- Finder flush against x=0 (cols 0..62) -> horz_patterns[18..44]=1.
- rst_in pulsed mid-VERT -> all outputs return to reset values the next cycle; no scan_done. A new start then completes normally.
- start_scan re-asserted while busy -> ignored; exactly one scan_done, with identical results.
